// File: rtl/sb_lsu_if.sv
// Word-wide req/ack data RAM port with byte enables; the LSU is the master, memory the slave.
interface sb_lsu_if #(
  parameter int ADDR_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;

  modport master (output req, we, addr, be, wdata, input rdata, ack);
  modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/sb_lsu.sv
// Load/store unit: one RAM access per instruction (IDLE -> ACCESS -> RESP), min 3 cycles.
// Holds the pipeline through IDLE-accept and ACCESS; flags misalignment and RAM timeouts on err_o.
module sb_lsu #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re_i,
  input  logic [31:0] mem_raddr_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [1:0]  byte_sel_i,
  input  logic        un_sign_i,
  input  logic [4:0]  rd_waddr_i,
  output logic        rd_we_o,
  output logic [4:0]  rd_waddr_o,
  output logic [31:0] rd_wdata_o,
  output logic        hold_o,
  output logic        err_o,
  sb_lsu_if.master    ram
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;

  logic [ADDR_W+1:0] lat_addr;
  logic [3:0]        lat_be;
  logic [31:0]       lat_wdata;
  logic              lat_we;
  logic [1:0]        lat_sel;
  logic              lat_uns;
  logic [4:0]        lat_rd;
  logic [CW-1:0]     cnt;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0] req_addr;
  logic        req_vld;
  logic        misal;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic        accept;
  logic        timed_out;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;
  logic        unused_bits;

  // A store wins when both strobes are up, so its address is the one checked.
  assign req_addr  = mem_we_i ? mem_waddr_i : mem_raddr_i;
  assign req_vld   = (mem_re_i | mem_we_i) & (byte_sel_i != 2'b11);
  assign misal     = ((byte_sel_i == 2'b01) & req_addr[0]) |
                     ((byte_sel_i == 2'b10) & (req_addr[1:0] != 2'b00));
  assign timed_out = (cnt == CW'(TIMEOUT - 1));
  assign unused_bits = ^{mem_raddr_i[31:ADDR_W+2], mem_waddr_i[31:ADDR_W+2]};

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = mem_wdata_i;
    case (byte_sel_i)
      2'b00: begin
        be_new    = 4'b0001 << req_addr[1:0];
        wdata_new = {4{mem_wdata_i[7:0]}};
      end
      2'b01: begin
        be_new    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{mem_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_b   = rdata_q[{lat_addr[1:0], 3'b000} +: 8];
    ld_h   = lat_addr[1] ? rdata_q[31:16] : rdata_q[15:0];
    ld_ext = rdata_q;
    case (lat_sel)
      2'b00:   ld_ext = {{24{ld_b[7] & ~lat_uns}}, ld_b};
      2'b01:   ld_ext = {{16{ld_h[15] & ~lat_uns}}, ld_h};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    hold_o     = 1'b0;
    err_o      = 1'b0;
    rd_we_o    = 1'b0;
    rd_waddr_o = '0;
    rd_wdata_o = '0;
    ram.req    = 1'b0;
    ram.we     = 1'b0;
    ram.addr   = '0;
    ram.be     = '0;
    ram.wdata  = '0;
    case (state)
      IDLE: begin
        if (!rst && req_vld) begin
          if (misal) begin
            err_o = 1'b1;
          end else begin
            hold_o    = 1'b1;
            accept    = 1'b1;
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        hold_o    = 1'b1;
        ram.req   = 1'b1;
        ram.we    = lat_we;
        ram.addr  = lat_addr[ADDR_W+1:2];
        ram.be    = lat_be;
        ram.wdata = lat_wdata;
        if (ram.ack || timed_out) state_nxt = RESP;
      end
      RESP: begin
        // Request inputs still belong to the retiring instruction; ignore them.
        state_nxt = IDLE;
        err_o     = err_q;
        if (!lat_we && !err_q && (lat_rd != 5'd0)) begin
          rd_we_o    = 1'b1;
          rd_waddr_o = lat_rd;
          rd_wdata_o = ld_ext;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr  <= '0;
      lat_be    <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_sel   <= '0;
      lat_uns   <= 1'b0;
      lat_rd    <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      lat_addr  <= req_addr[ADDR_W+1:0];
      lat_be    <= be_new;
      lat_wdata <= wdata_new;
      lat_we    <= mem_we_i;
      lat_sel   <= byte_sel_i;
      lat_uns   <= un_sign_i;
      lat_rd    <= rd_waddr_i;
      cnt       <= '0;
      err_q     <= 1'b0;
    end else if (state == ACCESS) begin
      cnt <= cnt + 1'b1;
      if (ram.ack)        rdata_q <= ram.rdata;
      else if (timed_out) err_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sb_lsu.sv
// Directed bench for sb_lsu: hand-computed vectors for stores, loads, misalignment, timeout and reset.
module tb_sb_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_re_i = 1'b0;
  logic [31:0] mem_raddr_i = '0;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_waddr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [1:0]  byte_sel_i = '0;
  logic        un_sign_i = 1'b0;
  logic [4:0]  rd_waddr_i = '0;
  logic        rd_we_o;
  logic [4:0]  rd_waddr_o;
  logic [31:0] rd_wdata_o;
  logic        hold_o;
  logic        err_o;

  sb_lsu_if #(.ADDR_W(16)) ram ();

  sb_lsu #(.ADDR_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_re_i(mem_re_i), .mem_raddr_i(mem_raddr_i),
    .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
    .byte_sel_i(byte_sel_i), .un_sign_i(un_sign_i), .rd_waddr_i(rd_waddr_i),
    .rd_we_o(rd_we_o), .rd_waddr_o(rd_waddr_o), .rd_wdata_o(rd_wdata_o),
    .hold_o(hold_o), .err_o(err_o), .ram(ram)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int          r_holds, r_reqs;
  logic        c_we;
  logic [15:0] c_addr;
  logic [3:0]  c_be;
  logic [31:0] c_wdata;
  logic        o_rdwe, o_err;
  logic [4:0]  o_rdaddr;
  logic [31:0] o_rdwdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Runs one instruction; acks on the ack_at-th request cycle (0 = never ack).
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] sel, input logic uns, input logic [4:0] rd,
                           input int ack_at, input logic [31:0] rdata);
    bit done = 0;
    r_holds = 0; r_reqs = 0;
    c_we = 0; c_addr = '0; c_be = '0; c_wdata = '0;
    o_rdwe = 0; o_err = 0; o_rdaddr = '0; o_rdwdata = '0;
    @(negedge clk);
    mem_re_i = !we; mem_we_i = we; mem_raddr_i = addr; mem_waddr_i = addr;
    mem_wdata_i = wd; byte_sel_i = sel; un_sign_i = uns; rd_waddr_i = rd;
    for (int k = 0; k < 40 && !done; k++) begin
      #1;
      if (hold_o) r_holds++;
      if (ram.req) begin
        r_reqs++;
        c_we = ram.we; c_addr = ram.addr; c_be = ram.be; c_wdata = ram.wdata;
        if (r_reqs == ack_at) begin
          ram.ack = 1'b1;
          ram.rdata = rdata;
        end
      end else if (k > 0 && !hold_o) begin
        done = 1;
        o_rdwe = rd_we_o; o_rdaddr = rd_waddr_o; o_rdwdata = rd_wdata_o; o_err = err_o;
      end
      @(negedge clk);
      ram.ack = 1'b0;
    end
    mem_re_i = 1'b0; mem_we_i = 1'b0;
    if (!done) chk("resp_reached", 32'd0, 32'd1);
  endtask

  initial begin
    ram.ack = 1'b0;
    ram.rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hold", hold_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_req", ram.req, 0);
    chk("rst_rdwe", rd_we_o, 0);
    chk("rst_be", ram.be, 0);
    @(negedge clk);
    rst = 1'b0;

    do_access(1, 32'h100, 32'hDEADBEEF, 2'b10, 0, 5'd0, 2, 32'h0);
    chk("sw_addr", c_addr, 32'h40);
    chk("sw_be", c_be, 4'hF);
    chk("sw_wdata", c_wdata, 32'hDEADBEEF);
    chk("sw_we", c_we, 1);
    chk("sw_rdwe", o_rdwe, 0);
    chk("sw_rdaddr", o_rdaddr, 0);
    chk("sw_holds", r_holds, 3);

    do_access(0, 32'h100, 32'h0, 2'b10, 0, 5'd5, 2, 32'hDEADBEEF);
    chk("lw_rdwe", o_rdwe, 1);
    chk("lw_rdaddr", o_rdaddr, 5);
    chk("lw_data", o_rdwdata, 32'hDEADBEEF);
    chk("lw_holds", r_holds, 3);
    chk("lw_we", c_we, 0);

    do_access(0, 32'h103, 32'h0, 2'b00, 0, 5'd6, 1, 32'h80FF00AA);
    chk("lb_data", o_rdwdata, 32'hFFFFFF80);
    chk("lb_be", c_be, 4'h8);
    chk("lb_holds", r_holds, 2);
    do_access(0, 32'h103, 32'h0, 2'b00, 1, 5'd6, 1, 32'h80FF00AA);
    chk("lbu_data", o_rdwdata, 32'h00000080);

    do_access(1, 32'h102, 32'h1234ABCD, 2'b01, 0, 5'd0, 1, 32'h0);
    chk("sh_be", c_be, 4'hC);
    chk("sh_wdata", c_wdata, 32'hABCDABCD);
    do_access(1, 32'h101, 32'h00000055, 2'b00, 0, 5'd0, 1, 32'h0);
    chk("sb_be", c_be, 4'h2);
    chk("sb_wdata", c_wdata, 32'h55555555);

    do_access(0, 32'h102, 32'h0, 2'b01, 0, 5'd9, 1, 32'h80FF00AA);
    chk("lh_data", o_rdwdata, 32'hFFFF80FF);
    chk("lh_be", c_be, 4'hC);
    do_access(0, 32'h100, 32'h0, 2'b01, 1, 5'd9, 1, 32'h80FF00AA);
    chk("lhu_data", o_rdwdata, 32'h000000AA);
    chk("lhu_be", c_be, 4'h3);

    // Misaligned word load
    @(negedge clk);
    mem_re_i = 1'b1; mem_raddr_i = 32'h101; byte_sel_i = 2'b10; rd_waddr_i = 5'd3;
    #1;
    chk("mis_err", err_o, 1);
    chk("mis_hold", hold_o, 0);
    chk("mis_req", ram.req, 0);
    @(negedge clk);
    mem_re_i = 1'b0;
    #1;
    chk("mis_err_clr", err_o, 0);
    chk("mis_req_after", ram.req, 0);
    chk("mis_rdwe", rd_we_o, 0);

    // No-op byte_sel=11 is not a request
    @(negedge clk);
    mem_re_i = 1'b1; mem_raddr_i = 32'h100; byte_sel_i = 2'b11;
    #1;
    chk("none_hold", hold_o, 0);
    @(negedge clk);
    mem_re_i = 1'b0;
    #1;
    chk("none_req", ram.req, 0);

    do_access(0, 32'h200, 32'h0, 2'b10, 0, 5'd4, 0, 32'h0);
    chk("to_reqs", r_reqs, 4);
    chk("to_err", o_err, 1);
    chk("to_rdwe", o_rdwe, 0);
    #1;
    chk("to_err_clr", err_o, 0);
    chk("to_idle_req", ram.req, 0);

    // Reset in the second ACCESS cycle
    @(negedge clk);
    mem_re_i = 1'b1; mem_raddr_i = 32'h200; byte_sel_i = 2'b10; rd_waddr_i = 5'd7;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    mem_re_i = 1'b0;
    #1;
    chk("rst_mid_req_held", ram.req, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_req", ram.req, 0);
    chk("rst_mid_hold", hold_o, 0);
    chk("rst_mid_rdwe", rd_we_o, 0);
    ram.ack = 1'b1; ram.rdata = 32'h12345678;
    @(negedge clk);
    ram.ack = 1'b0;
    #1;
    chk("late_ack_rdwe", rd_we_o, 0);
    chk("late_ack_req", ram.req, 0);

    do_access(0, 32'h100, 32'h0, 2'b10, 0, 5'd0, 1, 32'hCAFEF00D);
    chk("x0_rdwe", o_rdwe, 0);
    chk("x0_data", o_rdwdata, 0);
    chk("x0_holds", r_holds, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
